// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbitration controller: command
// word layout, controller FSM states and the default operand width.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 5;

    // Command word forwarded unchanged to the ALU enables/op selects.
    typedef struct packed {
        logic       op1_en;
        logic       op2_en;
        logic [2:0] op1_op;
        logic [1:0] op2_op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Plain addition: stage 1 enabled with op 000, stage 2 bypassed.
    localparam alu_cmd_t ALU_CMD_ADD = '{op1_en: 1'b1, op2_en: 1'b0,
                                         op1_op: 3'b000, op2_op: 2'b00};

endpackage

// File: rtl/alu_arb_ctrl_if.sv
// Requester-side command/response bus of alu_arb_ctrl: two lanes, each with
// a command handshake (valid/ready) and a result handshake (valid/ready).
interface alu_arb_ctrl_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    alu_cmd_t                     req_cmd [2];
    logic signed [DATA_WIDTH-1:0] req_a   [2];
    logic signed [DATA_WIDTH-1:0] req_b   [2];
    logic [1:0]                   rsp_valid;
    logic [1:0]                   rsp_ready;
    logic signed [DATA_WIDTH:0]   rsp_data [2];

    // Requesters issue commands and consume results.
    modport master (
        output req_valid, req_cmd, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    // The controller accepts commands and returns results.
    modport slave (
        input  req_valid, req_cmd, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_rr_arb.sv
// Two-way grant logic. With ALU_ARB_RR_EN defined the grant alternates
// between requesters when both are valid (pointer moves on accept only);
// otherwise requester 0 has fixed priority and no pointer state exists.
module alu_rr_arb (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    logic favour1;

    // One-hot grant; on contention the pointer picks the favoured requester.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = favour1 ? 2'b10 : 2'b01;
        end
    end

    // After an accept, favour the requester that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour1 <= 1'b0;
        end else if (accept) begin
            favour1 <= grant[0];
        end
    end
`else
    // Fixed priority: requester 0 always wins.
    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto one registered-output ALU, one transaction
// in flight: IDLE (accept) -> ISSUE (alu_en pulse) -> WAIT (capture alu_out)
// -> RESP (hold result until the granted requester takes it).
// Arbitration policy: round-robin when ALU_ARB_RR_EN is defined, fixed
// priority to requester 0 otherwise.
module alu_arb_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    alu_arb_ctrl_if.slave                 bus,
    output logic                          alu_en,
    output alu_cmd_t                      alu_cmd,
    output logic signed [DATA_WIDTH-1:0]  alu_operand1,
    output logic signed [DATA_WIDTH-1:0]  alu_operand2,
    input  logic signed [DATA_WIDTH:0]    alu_out
);

    state_t     state;
    logic       gnt_idx;
    logic [1:0] grant;
    logic       accept;

    alu_rr_arb u_arb (
`ifdef ALU_ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
`endif
        .req    (bus.req_valid),
        .grant  (grant)
    );

    // Ready is offered only in IDLE and never while reset is asserted, so a
    // valid held through reset cannot look accepted.
    assign bus.req_ready = (rst_n && (state == IDLE)) ? grant : 2'b00;
    assign accept        = |(bus.req_valid & bus.req_ready);

    // Transaction FSM; ALU drive and response lanes are registered here.
    // alu_cmd/operands double as the latched command, so they keep the last
    // issued values while alu_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt_idx       <= 1'b0;
            alu_en        <= 1'b0;
            alu_cmd       <= '0;
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_data[0] <= '0;
            bus.rsp_data[1] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_idx      <= grant[1];
                        alu_cmd      <= bus.req_cmd[grant[1]];
                        alu_operand1 <= bus.req_a[grant[1]];
                        alu_operand2 <= bus.req_b[grant[1]];
                        alu_en       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_en <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // ALU result is valid one edge after the alu_en edge.
                    bus.rsp_valid[gnt_idx] <= 1'b1;
                    bus.rsp_data[gnt_idx]  <= alu_out;
                    state                  <= RESP;
                end
                RESP: begin
                    if (bus.rsp_valid[gnt_idx] && bus.rsp_ready[gnt_idx]) begin
                        bus.rsp_valid         <= 2'b00;
                        bus.rsp_data[gnt_idx] <= '0;
                        state                 <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl with a behavioural registered ADD ALU.
// Expected grant order depends on ALU_ARB_RR_EN, matching the DUT build.
module tb_alu_arb_ctrl;
    import alu_pkg::*;

    localparam int DW = 5;

    logic clk = 1'b0;
    logic rst_n;

    logic                  alu_en;
    alu_cmd_t              alu_cmd;
    logic signed [DW-1:0]  alu_operand1;
    logic signed [DW-1:0]  alu_operand2;
    logic signed [DW:0]    alu_out;

    int n_chk  = 0;
    int n_fail = 0;

    alu_arb_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    alu_arb_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_en       (alu_en),
        .alu_cmd      (alu_cmd),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_out      (alu_out)
    );

    always #5 clk = ~clk;

    // Registered ALU model: ADD only, result sign-extended to DW+1 bits.
    initial alu_out = '0;
    always @(posedge clk) begin
        if (alu_en) begin
            if (alu_cmd == ALU_CMD_ADD) begin
                alu_out <= (DW+1)'(alu_operand1) + (DW+1)'(alu_operand2);
            end else begin
                alu_out <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with expected grant g and result exp_r; stall is
    // the number of extra RESP cycles with rsp_ready held low.
    task automatic txn(input string tag, input logic [1:0] valid, input int g,
                       input logic signed [DW-1:0] a0, input logic signed [DW-1:0] b0,
                       input logic signed [DW-1:0] a1, input logic signed [DW-1:0] b1,
                       input logic signed [DW:0] exp_r, input int stall);
        logic [1:0]           oh;
        logic signed [DW-1:0] ea;
        logic signed [DW-1:0] eb;
        oh = (g == 0) ? 2'b01 : 2'b10;
        ea = (g == 0) ? a0 : a1;
        eb = (g == 0) ? b0 : b1;
        bus.req_valid  = valid;
        bus.req_cmd[0] = ALU_CMD_ADD;
        bus.req_cmd[1] = ALU_CMD_ADD;
        bus.req_a[0]   = a0;
        bus.req_b[0]   = b0;
        bus.req_a[1]   = a1;
        bus.req_b[1]   = b1;
        #1;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(oh));
        tick();
        check({tag, ".issue_en"}, 32'(alu_en), 32'd1);
        check({tag, ".issue_cmd"}, 32'(alu_cmd), 32'(ALU_CMD_ADD));
        check({tag, ".issue_op1"}, 32'(alu_operand1), 32'(ea));
        check({tag, ".issue_op2"}, 32'(alu_operand2), 32'(eb));
        check({tag, ".issue_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, ".issue_rspv"}, 32'(bus.rsp_valid), 32'd0);
        tick();
        check({tag, ".wait_en"}, 32'(alu_en), 32'd0);
        check({tag, ".wait_rspv"}, 32'(bus.rsp_valid), 32'd0);
        tick();
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
        check({tag, ".rsp_data"}, 32'(bus.rsp_data[g]), 32'(exp_r));
        check({tag, ".rsp_other"}, 32'(bus.rsp_data[1-g]), 32'd0);
        check({tag, ".rsp_en"}, 32'(alu_en), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, ".stall_valid"}, 32'(bus.rsp_valid), 32'(oh));
            check({tag, ".stall_data"}, 32'(bus.rsp_data[g]), 32'(exp_r));
            check({tag, ".stall_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, ".stall_en"}, 32'(alu_en), 32'd0);
        end
        bus.rsp_ready = oh;
        tick();
        check({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".done_data"}, 32'(bus.rsp_data[g]), 32'd0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        bus.req_valid  = 2'b00;
        bus.rsp_ready  = 2'b00;
        bus.req_cmd[0] = '0;
        bus.req_cmd[1] = '0;
        bus.req_a[0]   = '0;
        bus.req_b[0]   = '0;
        bus.req_a[1]   = '0;
        bus.req_b[1]   = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst.req_ready", 32'(bus.req_ready), 32'd0);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_data0", 32'(bus.rsp_data[0]), 32'd0);
        check("rst.rsp_data1", 32'(bus.rsp_data[1]), 32'd0);
        check("rst.alu_en", 32'(alu_en), 32'd0);
        check("rst.alu_cmd", 32'(alu_cmd), 32'd0);
        check("rst.op1", 32'(alu_operand1), 32'd0);
        check("rst.op2", 32'(alu_operand2), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requests on each lane, including the most negative sum.
        txn("add0", 2'b01, 0, 5'sd3, 5'sd4, 5'sd0, 5'sd0, 6'sd7, 0);
        txn("add1", 2'b10, 1, 5'sd0, 5'sd0, -5'sd16, -5'sd16, -6'sd32, 0);

        // Both lanes valid throughout.
        txn("both0", 2'b11, 0, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd3, 0);
`ifdef ALU_ARB_RR_EN
        txn("both1", 2'b11, 1, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd11, 0);
        txn("both2", 2'b11, 0, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd3, 0);
        txn("both3", 2'b11, 1, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd11, 0);
`else
        txn("both1", 2'b11, 0, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd3, 0);
        txn("both2", 2'b11, 0, 5'sd1, 5'sd2, 5'sd5, 5'sd6, 6'sd3, 0);
`endif

        // Response back-pressure for 5 cycles.
        txn("stall", 2'b11, 0, -5'sd3, 5'sd5, 5'sd4, 5'sd4, 6'sd2, 5);

        // Reset while in WAIT: transaction dropped, pointer back to req0.
        bus.req_valid = 2'b01;
        bus.req_a[0]  = 5'sd2;
        bus.req_b[0]  = 5'sd2;
        tick();
        check("rstw.accept_en", 32'(alu_en), 32'd1);
        tick();
        bus.req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check("rstw.alu_en", 32'(alu_en), 32'd0);
        check("rstw.alu_cmd", 32'(alu_cmd), 32'd0);
        check("rstw.op1", 32'(alu_operand1), 32'd0);
        check("rstw.op2", 32'(alu_operand2), 32'd0);
        check("rstw.req_ready", 32'(bus.req_ready), 32'd0);
        check("rstw.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rstw.hold_valid", 32'(bus.rsp_valid), 32'd0);
            check("rstw.hold_data0", 32'(bus.rsp_data[0]), 32'd0);
        end
        rst_n = 1'b1;
        txn("post_rst", 2'b11, 0, 5'sd1, 5'sd1, 5'sd7, 5'sd7, 6'sd2, 0);
        bus.req_valid = 2'b00;
        tick();
        check("idle.alu_en", 32'(alu_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 5, signed operand width; result width is DATA_WIDTH+1.
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  2  per-requester command valid.
REQ-005 Port: req_ready  out  2  per-requester command accept.
REQ-006 Port: req_cmd  in  2x7  per-requester alu_cmd_t {op1_en, op2_en, op1_op[2:0], op2_op[1:0]}.
REQ-007 Port: req_a / req_b  in  2xDATA_WIDTH  per-requester signed operands.
REQ-008 Port: rsp_valid / rsp_ready  out / in  2 / 2  per-requester result handshake.
REQ-009 Port: rsp_data  out  2x(DATA_WIDTH+1)  per-requester signed result.
REQ-010 Port: alu_en  out  1  ALU enable.
REQ-011 Port: alu_cmd  out  7  alu_cmd_t driven to ALU enables/op selects.
REQ-012 Port: alu_operand1 / alu_operand2  out  DATA_WIDTH  signed operands to ALU.
REQ-013 Port: alu_out  in  DATA_WIDTH+1  ALU registered result (1-cycle latency from alu_en edge).

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-015 IDLE: req_ready SHALL be the one-hot grant of the arbiter over req_valid; all-zero in every other state.
REQ-016 Accept = req_valid[i] & req_ready[i]; on accept edge latch cmd/a/b/grant index, go ISSUE.
REQ-017 ISSUE (exactly 1 cycle): alu_en=1, alu_cmd/operands = latched values; next WAIT.
REQ-018 WAIT (exactly 1 cycle): alu_en=0; at end of WAIT capture alu_out into result register; next RESP.
REQ-019 RESP: rsp_valid[grant]=1, rsp_data[grant]=captured result; leave to IDLE on rsp_valid&rsp_ready edge.
REQ-020 Latency: rsp_valid rises 3 edges after accept edge (ISSUE, WAIT, capture); minimum turnaround 4 cycles.
REQ-021 alu_en SHALL be 0 outside ISSUE; alu_cmd/operands SHALL hold last issued values when alu_en=0.
REQ-022 rsp_valid/rsp_data SHALL hold stable while rsp_ready=0; no new accept while in RESP.
REQ-023 Non-granted rsp_valid bit and rsp_data lane SHALL be 0.
REQ-024 Commands forwarded unchecked; result is alu_out bit-exact, no extension or saturation.
REQ-025 Simultaneous req_valid on both: grant per arbitration policy (REQ-029/030).

Reset
REQ-026 rst_n low at any time (incl. mid-ISSUE/WAIT/RESP): state IDLE, in-flight transaction dropped, no response.
REQ-027 Reset values: req_ready=0, rsp_valid=0, rsp_data=0, alu_en=0, alu_cmd=0, operands=0, RR pointer favours req0.
REQ-028 First accept permitted on first rising edge after rst_n deasserts.

Configuration
REQ-029 ALU_ARB_RR_EN defined: round-robin; on both valid, grant requester not granted last; pointer updates on accept only.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, req0 always wins; no pointer state.

Structure
REQ-031 Package alu_pkg: DATA_WIDTH default, alu_cmd_t packed struct, state enum, ADD encoding constant (op1_en=1, op2_en=0, op1_op=000).
REQ-032 Sub-module alu_rr_arb: 2-way grant logic with pointer, macro-controlled policy.

Verification
REQ-033 req0 ADD a=3 b=4 -> alu_en pulse 1 cycle after accept; rsp_valid[0] 3 edges after accept, rsp_data[0]=7.
REQ-034 req1 ADD a=-16 b=-16 -> rsp_data[1]=-32 (6'b100000), rsp_valid[0]=0 throughout.
REQ-035 Both valid continuously, ALU_ARB_RR_EN -> grants 0,1,0,1; undefined -> grants 0,0,0, req1 starved.
REQ-036 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, alu_en=0 throughout.
REQ-037 rst_n low during WAIT -> all outputs 0 asynchronously, no rsp_valid; next ADD 1+1 returns 2.
REQ-038 Check alu_en=0 implies alu_out stable next cycle and alu_out never X while alu_en=1 after reset.
